// File: rtl/gpo_core_if.sv
// Slot bus shared by the SoC I/O cores.
// Signals:
//   cs         - slot select
//   read       - read strobe (reads have no side effects)
//   write      - write strobe
//   addr       - register word address
//   write_data - write data
//   read_data  - combinational read data from the selected slot
// Modports: master drives the strobes, address and write data; slave returns read_data.
interface gpo_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output cs,
    output read,
    output write,
    output addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  cs,
    input  read,
    input  write,
    input  addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/gpo_core.sv
// General-purpose output core on the slot bus.
// A W-bit output register is updated by direct write, set, clear or toggle. A one-shot pulse
// engine can also force masked bits high for a programmed number of cycles.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset
//   bus      - slot bus (slave side): cs/read/write/addr/write_data in, read_data out
//   data_out - registered output port, out_reg OR'ed with the active pulse mask
// Register map: 0 DATA, 1 SET, 2 CLR, 3 TOG, 4 PLEN, 5 PULSE, 6 STATUS; all others read 0.
module gpo_core #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  gpo_core_if.slave        bus,
  output logic [W-1:0]     data_out
);

  localparam logic [4:0] AddrData   = 5'd0;
  localparam logic [4:0] AddrSet    = 5'd1;
  localparam logic [4:0] AddrClr    = 5'd2;
  localparam logic [4:0] AddrTog    = 5'd3;
  localparam logic [4:0] AddrPlen   = 5'd4;
  localparam logic [4:0] AddrPulse  = 5'd5;
  localparam logic [4:0] AddrStatus = 5'd6;

  typedef enum logic {StIdle, StActive} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     out_q, out_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [W-1:0]     pmask_q, pmask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     data_out_q, data_out_d;

  logic         wr_en;
  logic [W-1:0] wd_w;
  logic         pulse_launch;

  assign wr_en = bus.cs && bus.write;
  assign wd_w  = bus.write_data[W-1:0];

  // Launches with an empty mask or zero length are dropped in either state.
  assign pulse_launch = wr_en && (bus.addr == AddrPulse) && (wd_w != '0) && (plen_q != '0);

  // Bus-side register updates.
  always_comb begin
    out_d  = out_q;
    plen_d = plen_q;
    if (wr_en) begin
      case (bus.addr)
        AddrData: out_d  = wd_w;
        AddrSet:  out_d  = out_q | wd_w;
        AddrClr:  out_d  = out_q & ~wd_w;
        AddrTog:  out_d  = out_q ^ wd_w;
        AddrPlen: plen_d = bus.write_data[CNT_W-1:0];
        default:  ;
      endcase
    end
  end

  // Pulse FSM. A valid launch while active reloads mask and count ahead of the decrement.
  always_comb begin
    state_d = state_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pulse_launch) begin
          state_d = StActive;
          pmask_d = wd_w;
          cnt_d   = plen_q;
        end
      end
      StActive: begin
        if (pulse_launch) begin
          pmask_d = wd_w;
          cnt_d   = plen_q;
        end else if (cnt_q == CNT_W'(1)) begin
          // Mask is kept so software can still read which bits were pulsed.
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output is built from next-state values so the pin updates in the same cycle as the registers.
  always_comb begin
    data_out_d = out_d;
    if (state_d == StActive) begin
      data_out_d = out_d | pmask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      out_q      <= '0;
      plen_q     <= '0;
      pmask_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      plen_q     <= plen_d;
      pmask_q    <= pmask_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

  // Read mux ignores cs and read: reads carry no side effects.
  always_comb begin
    bus.read_data = '0;
    case (bus.addr)
      AddrData:   bus.read_data = 32'(out_q);
      AddrPlen:   bus.read_data = 32'(plen_q);
      AddrPulse:  bus.read_data = 32'(pmask_q);
      AddrStatus: begin
        bus.read_data[0]           = (state_q == StActive);
        bus.read_data[16 +: CNT_W] = cnt_q;
      end
      default:    bus.read_data = '0;
    endcase
  end

  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.write_data};

endmodule

// File: tb/tb_gpo_core.sv
module tb_gpo_core;
  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_out;

  gpo_core_if bus ();

  gpo_core #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dout;
    logic [4:0]   raddr;
    logic [31:0]  rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, push expectation, then after the edge check data_out and
  // the read value at raddr.
  task automatic step(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d,
                      input logic [W-1:0] exp_dout, input logic [4:0] ra,
                      input logic [31:0] exp_rd);
    exp_t e;
    exp_t got_e;
    @(negedge clk);
    bus.cs         = c;
    bus.read       = 1'b0;
    bus.write      = w;
    bus.addr       = a;
    bus.write_data = d;
    e.dout  = exp_dout;
    e.raddr = ra;
    e.rdata = exp_rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    n_step++;
    check($sformatf("dout@%0d", n_step), 32'(data_out), 32'(got_e.dout));
    bus.cs    = 1'b1;
    bus.read  = 1'b1;
    bus.write = 1'b0;
    bus.addr  = got_e.raddr;
    #1;
    check($sformatf("rd%0d@%0d", got_e.raddr, n_step), bus.read_data, got_e.rdata);
  endtask

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.write_data = '0;
    rst = 1'b0;

    // Reset: outputs and all readable registers are zero.
    step(0, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 0, 0, 4'h0, 6, 0);
    step(0, 0, 0, 0, 4'h0, 4, 0);
    step(0, 0, 0, 0, 4'h0, 5, 0);
    rst = 1'b1;

    // Direct write and set/clear/toggle, with cs=0 writes ignored.
    step(1, 1, 0, 32'hA, 4'hA, 0, 32'hA);
    step(0, 1, 0, 32'h5, 4'hA, 0, 32'hA);
    step(1, 1, 1, 32'h1, 4'hB, 0, 32'hB);
    step(0, 1, 1, 32'h4, 4'hB, 1, 0);
    step(1, 1, 2, 32'h8, 4'h3, 0, 32'h3);
    step(1, 1, 3, 32'hF, 4'hC, 0, 32'hC);
    step(0, 1, 3, 32'hF, 4'hC, 3, 0);
    step(1, 1, 6, 32'hFFFF_FFFF, 4'hC, 6, 0);
    step(1, 1, 9, 32'hF, 4'hC, 9, 0);
    step(0, 0, 0, 0, 4'hC, 2, 0);

    // Pulse of length 5 on bit 2.
    step(1, 1, 0, 32'h0, 4'h0, 0, 0);
    step(1, 1, 4, 32'd5, 4'h0, 4, 32'd5);
    step(1, 1, 5, 32'h4, 4'h4, 6, 32'h0005_0001);
    for (int i = 4; i >= 1; i--) step(0, 0, 0, 0, 4'h4, 6, (32'(i) << 16) | 32'h1);
    step(0, 0, 0, 0, 4'h0, 6, 0);
    step(0, 0, 0, 0, 4'h0, 5, 32'h4);

    // Retrigger and OR composition with out_reg.
    step(1, 1, 0, 32'h1, 4'h1, 0, 32'h1);
    step(1, 1, 4, 32'd3, 4'h1, 4, 32'd3);
    step(1, 1, 5, 32'h6, 4'h7, 6, 32'h0003_0001);
    step(0, 0, 0, 0, 4'h7, 6, 32'h0002_0001);
    step(1, 1, 5, 32'h8, 4'h9, 6, 32'h0003_0001);
    step(0, 0, 0, 0, 4'h9, 6, 32'h0002_0001);
    step(0, 0, 0, 0, 4'h9, 6, 32'h0001_0001);
    step(0, 0, 0, 0, 4'h1, 6, 0);
    step(0, 0, 0, 0, 4'h1, 5, 32'h8);

    // Ignored launches: zero mask, zero length.
    step(1, 1, 5, 32'h0, 4'h1, 6, 0);
    step(0, 0, 0, 0, 4'h1, 5, 32'h8);
    step(1, 1, 4, 32'd0, 4'h1, 4, 0);
    step(1, 1, 5, 32'hF, 4'h1, 6, 0);
    step(0, 0, 0, 0, 4'h1, 5, 32'h8);

    // Zero-mask launch while active does not disturb the running pulse.
    step(1, 1, 4, 32'd2, 4'h1, 4, 32'd2);
    step(1, 1, 5, 32'h2, 4'h3, 6, 32'h0002_0001);
    step(1, 1, 5, 32'h0, 4'h3, 6, 32'h0001_0001);
    step(0, 0, 0, 0, 4'h1, 6, 0);

    // PLEN write while active only affects the next launch.
    step(1, 1, 4, 32'd4, 4'h1, 4, 32'd4);
    step(1, 1, 5, 32'h2, 4'h3, 6, 32'h0004_0001);
    step(1, 1, 4, 32'd9, 4'h3, 6, 32'h0003_0001);
    step(0, 0, 0, 0, 4'h3, 6, 32'h0002_0001);
    step(0, 0, 0, 0, 4'h3, 6, 32'h0001_0001);
    step(0, 0, 0, 0, 4'h1, 4, 32'd9);

    // Reset in the middle of a long pulse.
    step(1, 1, 0, 32'h0, 4'h0, 0, 0);
    step(1, 1, 4, 32'd100, 4'h0, 4, 32'd100);
    step(1, 1, 5, 32'hF, 4'hF, 6, 32'h0064_0001);
    for (int i = 2; i <= 9; i++) step(0, 0, 0, 0, 4'hF, 6, (32'(101 - i) << 16) | 32'h1);
    rst = 1'b0;
    step(0, 0, 0, 0, 4'h0, 6, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 4'h0, 6, 0);
    step(0, 0, 0, 0, 4'h0, 5, 0);
    step(0, 0, 0, 0, 4'h0, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
